// File: rtl/mux_arb_chan.sv
// mux_arb_chan: registered N-channel valid/ready mux, explicit-select (MODE 0) or round-robin (MODE 1).
// Define MUX_ARB_CHAN_PKT_LOCK_EN to hold a granted channel until its in_last beat is accepted.
module mux_arb_chan #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 10,
   parameter int MODE     = 0,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   input  logic [CHANNELS-1:0]       in_valid,
`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
   input  logic [CHANNELS-1:0]       in_last,
`endif
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sel_err
);
   logic                  r_out_valid, r_sel_err;
   logic [WIDTH-1:0]      r_out_data;
   logic [SEL_W-1:0]      r_out_chan, r_rr_ptr;
   logic                  w_load, w_sel_ok, w_rr_gv, w_gv, w_locked, w_acc, w_rr_upd;
   logic [SEL_W-1:0]      w_rr_idx, w_gidx, w_rr_nxt;
   logic [2*CHANNELS-1:0] w_dbl;
   logic [CHANNELS-1:0]   w_grant;
   logic [WIDTH-1:0]      w_data;

   assign w_load   = ~r_out_valid | out_ready;
   assign w_sel_ok = int'(sel) < CHANNELS;
   assign w_acc    = w_gv & w_load;
   assign w_rr_nxt = (w_gidx == SEL_W'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
   assign in_ready = w_grant & {CHANNELS{w_load & reset_n}};

   // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
   assign w_dbl = {in_valid, in_valid} >> r_rr_ptr;

   always_comb begin
      w_rr_gv  = 1'b0;
      w_rr_idx = '0;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (w_dbl[k]) begin
            w_rr_gv  = 1'b1;
            w_rr_idx = SEL_W'((int'(r_rr_ptr) + k) % CHANNELS);
         end
   end

`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
   typedef enum logic {S_IDLE, S_LOCKED} state_t;
   state_t           r_state, w_state_nxt;
   logic [SEL_W-1:0] r_lock_chan;
   logic             w_last;

   assign w_last   = |(in_last & w_grant);
   assign w_locked = r_state == S_LOCKED;
   assign w_rr_upd = w_acc & w_last;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_lock_chan <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc && !w_last) r_lock_chan <= w_gidx;
      end

   always_comb begin
      w_state_nxt = r_state;
      if (w_acc) w_state_nxt = w_last ? S_IDLE : S_LOCKED;
   end
`else
   assign w_locked = 1'b0;
   assign w_rr_upd = w_acc;
`endif

   always_comb begin
      w_gidx = (MODE == 1) ? w_rr_idx : sel;
      w_gv   = (MODE == 1) ? w_rr_gv : w_sel_ok & in_valid[sel];
`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
      if (w_locked) begin
         w_gidx = r_lock_chan;
         w_gv   = in_valid[r_lock_chan];
      end
`endif
   end

   always_comb begin
      w_grant = '0;
      w_data  = '0;
      for (int k = 0; k < CHANNELS; k++)
         if (w_gv && SEL_W'(k) == w_gidx) begin
            w_grant[k] = 1'b1;
            w_data     = in_bus[k*WIDTH +: WIDTH];
         end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_sel_err   <= 1'b0;
         r_rr_ptr    <= '0;
      end else begin
         r_sel_err <= w_load & (MODE == 0) & ~w_sel_ok & ~w_locked;
         if (w_rr_upd) r_rr_ptr <= w_rr_nxt;
         if (w_load) begin
            r_out_valid <= w_gv;
            if (w_gv) begin
               r_out_data <= w_data;
               r_out_chan <= w_gidx;
            end
         end
      end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign sel_err   = r_sel_err;
endmodule

// File: tb/tb_mux_arb_chan.sv
// tb_mux_arb_chan: MODE 0 and MODE 1 instances on shared inputs, checked against a per-cycle behavioural model.
module tb_mux_arb_chan;
   localparam int W = 32, N = 10, SW = 4;
   logic           clk = 1'b0, reset_n = 1'b0;
   logic [N*W-1:0] in_bus;
   logic [N-1:0]   in_valid, in_last, rdy0, rdy1;
   logic [SW-1:0]  sel, chan0, chan1;
   logic [W-1:0]   data0, data1;
   logic           out_ready, v0, v1, err0, err1;
   int             n_tot = 0, n_bad = 0;
   bit             m_v [2], m_e [2], m_lk [2], ld [2];
   logic [W-1:0]   m_d [2];
   int             m_c [2], m_rr [2], m_lch [2], g [2];
   int             exp6 [4] = '{2, 2, 2, 5};

   always #5 clk = ~clk;

   mux_arb_chan #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u0 (
      .clk(clk), .reset_n(reset_n), .in_bus(in_bus), .in_valid(in_valid),
`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
      .in_last(in_last),
`endif
      .in_ready(rdy0), .sel(sel), .out_data(data0), .out_chan(chan0),
      .out_valid(v0), .out_ready(out_ready), .sel_err(err0));

   mux_arb_chan #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u1 (
      .clk(clk), .reset_n(reset_n), .in_bus(in_bus), .in_valid(in_valid),
`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
      .in_last(in_last),
`endif
      .in_ready(rdy1), .sel(sel), .out_data(data1), .out_chan(chan1),
      .out_valid(v1), .out_ready(out_ready), .sel_err(err1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_v[m] = 0; m_e[m] = 0; m_lk[m] = 0; m_d[m] = '0; m_c[m] = 0; m_rr[m] = 0; m_lch[m] = 0;
      end
   endtask

   // Winning channel for instance m under the current inputs, or -1 for none.
   function automatic int pick(int m);
      if (m_lk[m]) return in_valid[m_lch[m]] ? m_lch[m] : -1;
      if (m == 0) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
      for (int i = 0; i < N; i++)
         if (in_valid[(m_rr[m] + i) % N]) return (m_rr[m] + i) % N;
      return -1;
   endfunction

   task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] last, input logic [SW-1:0] s, input logic ordy);
      logic [N-1:0] e [2];
      @(negedge clk);
      in_valid = v; in_last = last; sel = s; out_ready = ordy;
      #1;
      for (int m = 0; m < 2; m++) begin
         ld[m] = !m_v[m] || out_ready;
         g[m]  = pick(m);
         e[m]  = '0;
         if (g[m] >= 0 && ld[m]) e[m][g[m]] = 1'b1;
      end
      chk("rdy0", rdy0, e[0]);
      chk("rdy1", rdy1, e[1]);
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         m_e[m] = (m == 0) && ld[m] && int'(sel) >= N && !m_lk[m];
         if (ld[m]) begin
            m_v[m] = g[m] >= 0;
            if (g[m] >= 0) begin
               m_d[m] = in_bus[g[m]*W +: W];
               m_c[m] = g[m];
`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
               if (in_last[g[m]]) begin
                  m_lk[m] = 0;
                  m_rr[m] = (g[m] + 1) % N;
               end else begin
                  m_lk[m]  = 1;
                  m_lch[m] = g[m];
               end
`else
               m_rr[m] = (g[m] + 1) % N;
`endif
            end
         end
      end
      #1;
      chk("valid0", v0, m_v[0]);   chk("valid1", v1, m_v[1]);
      chk("data0", data0, m_d[0]); chk("data1", data1, m_d[1]);
      chk("chan0", chan0, m_c[0]); chk("chan1", chan1, m_c[1]);
      chk("err0", err0, m_e[0]);   chk("err1", err1, m_e[1]);
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      in_valid = '0; sel = '0;
      #1;
      chk("arst_v0", v0, 0);
      chk("arst_v1", v1, 0);
      chk("arst_rdy", rdy1, 0);
      model_reset();
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic rand_bus();
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = $urandom;
   endtask

   initial begin
      in_bus = '0; in_valid = '0; in_last = '0; sel = '0; out_ready = 1'b0;
      model_reset();
      #1 in_valid = '1;
      #1;
      chk("rst_v0", v0, 0);   chk("rst_v1", v1, 0);
      chk("rst_d1", data1, 0); chk("rst_c1", chan1, 0);
      chk("rst_err", err0, 0); chk("rst_rdy1", rdy1, 0);
      in_valid = '0;
      @(negedge clk) reset_n = 1'b1;

      rand_bus();
      in_bus[3*W +: W] = 32'hDEAD_BEEF;
      cyc(10'h008, '0, 4'd3, 1'b1);
      chk("t1_data", data0, 32'hDEAD_BEEF);
      chk("t1_chan", chan0, 3);
      chk("t1_valid", v0, 1);

      cyc(10'h008, '0, 4'd12, 1'b1);
      chk("t2_err", err0, 1);
      chk("t2_valid", v0, 0);
      cyc('0, '0, 4'd3, 1'b1);
      chk("t2_pulse", err0, 0);

      cyc('1, '0, 4'd0, 1'b1);
      async_reset();

      for (int i = 0; i < 12; i++) begin
         rand_bus();
         cyc('1, '0, 4'd0, 1'b1);
         chk("t3_chan", chan1, i % N);
         chk("t3_valid", v1, 1);
      end

      for (int i = 0; i < 3; i++) begin
         rand_bus();
         cyc('1, '0, 4'd0, 1'b0);
         chk("t4_hold", chan1, 1);
      end
      cyc('1, '0, 4'd0, 1'b1);
      chk("t4_next", chan1, 2);
      chk("t4_valid", v1, 1);

`ifdef MUX_ARB_CHAN_PKT_LOCK_EN
      async_reset();
      for (int b = 0; b < 4; b++) begin
         rand_bus();
         cyc(10'h024, (b == 2) ? 10'h004 : 10'h000, 4'd2, 1'b1);
         chk("t6_chan", chan1, exp6[b]);
      end
`endif

      for (int i = 0; i < 500; i++) begin
         rand_bus();
         cyc(($urandom_range(0, 4) == 0) ? '0 : N'($urandom), N'($urandom),
             SW'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
         if (i == 250) async_reset();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
